// File: rtl/led_run_monitor.sv
// Running-light LED bus reader: recovers step direction and period from the
// active-low one-cold LED pattern and classifies the period into a speed mode.
module led_run_monitor #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned TH01  = 1800000,
  parameter int unsigned TH12  = 3750000,
  parameter int unsigned TH23  = 7500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       prled_n,
  output logic             valid,
  output logic             dir,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] period,
  output logic             step_stb,
  output logic             err
);

  localparam logic [CNT_W-1:0] T01 = CNT_W'(TH01);
  localparam logic [CNT_W-1:0] T12 = CNT_W'(TH12);
  localparam logic [CNT_W-1:0] T23 = CNT_W'(TH23);

  typedef enum logic [1:0] {IDLE, SYNC1, SYNC2, LOCK} state_t;

  state_t           state;
  logic [3:0]       sync_a, sync_b, prev;
  logic [CNT_W-1:0] cnt, period_next;
  logic             dir_tmp;
  logic             legal, changed, step_ok, bad, step_dir, cnt_max;
  logic [1:0]       delta, mode_next;

  function automatic logic [1:0] pos_of(input logic [3:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int unsigned i = 0; i < 4; i++)
      if (!p[i]) r = 2'(i);
    return r;
  endfunction

  always_comb begin
    legal       = (sync_b == 4'b1110) || (sync_b == 4'b1101) ||
                  (sync_b == 4'b1011) || (sync_b == 4'b0111);
    changed     = (sync_b != prev);
    // delta 1 = forward, 3 = backward, 2 = illegal jump (mod-4 arithmetic)
    delta       = pos_of(sync_b) - pos_of(prev);
    step_ok     = changed && legal && delta[0];
    bad         = changed && !(legal && delta[0]);
    step_dir    = delta[1];
    cnt_max     = &cnt;
    period_next = cnt_max ? cnt : cnt + CNT_W'(1);
    mode_next   = 2'd3;
    if (period_next < T01)      mode_next = 2'd0;
    else if (period_next < T12) mode_next = 2'd1;
    else if (period_next < T23) mode_next = 2'd2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a   <= '1;
      sync_b   <= '1;
      prev     <= '1;
      cnt      <= '0;
      state    <= IDLE;
      dir_tmp  <= 1'b0;
      valid    <= 1'b0;
      dir      <= 1'b0;
      mode     <= '0;
      period   <= '0;
      step_stb <= 1'b0;
      err      <= 1'b0;
    end else begin
      sync_a   <= prled_n;
      sync_b   <= sync_a;
      prev     <= sync_b;
      step_stb <= 1'b0;
      err      <= 1'b0;
      if (!cnt_max) cnt <= cnt + CNT_W'(1);

      if (state == IDLE) begin
        if (legal) begin
          state <= SYNC1;
          cnt   <= '0;
        end
      end else if (bad) begin
        err   <= 1'b1;
        valid <= 1'b0;
        state <= IDLE;
        cnt   <= '0;
      end else if (step_ok) begin
        cnt <= '0;
        if (state == SYNC1) begin
          state   <= SYNC2;
          dir_tmp <= step_dir;
        end else if (state == SYNC2 && step_dir != dir_tmp) begin
          dir_tmp <= step_dir;
        end else begin
          state    <= LOCK;
          valid    <= 1'b1;
          dir      <= step_dir;
          period   <= period_next;
          mode     <= mode_next;
          step_stb <= 1'b1;
        end
      end else if (cnt_max && state != SYNC1) begin
        // a step arriving on the saturating cycle wins over the timeout
        state <= SYNC1;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_run_monitor.sv
// Scoreboard bench for led_run_monitor: a timeline model predicts output
// events (step, error, lock loss) which a monitor compares as they appear.
module tb_led_run_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TH01  = 20;
  localparam int unsigned TH12  = 40;
  localparam int unsigned TH23  = 80;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       prled_n = 4'b1111;
  logic             valid, dir, step_stb, err;
  logic [1:0]       mode;
  logic [CNT_W-1:0] period;

  led_run_monitor #(.CNT_W(CNT_W), .TH01(TH01), .TH12(TH12), .TH23(TH23)) dut (
    .clk(clk), .rst(rst), .prled_n(prled_n), .valid(valid), .dir(dir),
    .mode(mode), .period(period), .step_stb(step_stb), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       stb;
    logic       er;
    logic       vld;
    logic       d;
    logic [1:0] m;
    logic [7:0] per;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  done = 1'b0;

  // Reference model: lock progress counts consecutive same-direction steps
  // since the last sync point (0 = waiting for a legal pattern, 3 = locked).
  int         stage = 0;
  int         clr = 0;
  logic [3:0] mprev = 4'b1111;
  logic       mdir = 1'b0, dtmp = 1'b0;
  logic [1:0] mmode = 2'd0;
  logic [7:0] mper = 8'd0;
  logic [3:0] cur = 4'b1111;
  logic [1:0] cpos = 2'd0;

  function automatic bit legal(input logic [3:0] p);
    return $countones(p) == 3;
  endfunction

  function automatic logic [1:0] posn(input logic [3:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!p[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [3:0] pat_at(input logic [1:0] p);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << p);
  endfunction

  function automatic void push_ev(input int t, input logic s, input logic e, input logic v);
    ev_t x;
    x.cyc = t; x.stb = s; x.er = e; x.vld = v; x.d = mdir; x.m = mmode; x.per = mper;
    q.push_back(x);
  endfunction

  function automatic void model_accept(input int t, input logic d);
    int g;
    g     = t - clr;
    mper  = (g > 255) ? 8'd255 : 8'(g);
    mmode = (mper < TH01) ? 2'd0 : (mper < TH12) ? 2'd1 : (mper < TH23) ? 2'd2 : 2'd3;
    mdir  = d;
    push_ev(t, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic void model_change(input logic [3:0] np, input int t);
    logic [1:0] diff;
    if (np == mprev) return;
    diff = posn(np) - posn(mprev);
    if (stage == 0) begin
      if (legal(np)) begin stage = 1; clr = t; end
    end else if (!legal(np) || diff == 2'd2) begin
      push_ev(t, 1'b0, 1'b1, 1'b0);
      if (legal(np)) begin stage = 1; clr = t + 1; end
      else stage = 0;
    end else begin
      if (stage == 1) begin
        stage = 2; dtmp = (diff == 2'd3);
      end else if (stage == 2 && (diff == 2'd3) != dtmp) begin
        dtmp = (diff == 2'd3);
      end else begin
        model_accept(t, diff == 2'd3);
        stage = 3;
      end
      clr = t;
    end
    mprev = np;
  endfunction

  // A gap of 257+ cycles since the last sync point loses lock at clr+256.
  function automatic void model_timeout(input int tn);
    if (stage != 0 && tn - clr >= 257) begin
      if (stage == 3) push_ev(clr + 256, 1'b0, 1'b0, 1'b0);
      stage = 1;
    end
  endfunction

  task automatic apply(input logic [3:0] p, input int hold);
    @(negedge clk);
    prled_n = p;
    model_change(p, cyc + 3);
    model_timeout(cyc + 3 + hold);
    cur = p;
    if (legal(p)) cpos = posn(p);
    repeat (hold) @(posedge clk);
  endtask

  // Monitor: reset values while rst is low, scoreboard pops otherwise.
  logic last_valid = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      last_valid = 1'b0;
      vectors++;
      if ({valid, dir, mode, period, step_stb, err} !== '0) begin
        miscompares++;
        $display("FAIL reset_values cyc=%0d got valid=%b dir=%b mode=%0d period=%0d stb=%b err=%b, required all 0",
                 cyc, valid, dir, mode, period, step_stb, err);
      end
    end else if (done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_event required at cyc=%0d stb=%b err=%b valid=%b dir=%b mode=%0d period=%0d, got nothing",
                 e.cyc, e.stb, e.er, e.vld, e.d, e.m, e.per);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else if (step_stb || err || valid !== last_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output cyc=%0d got stb=%b err=%b valid=%b dir=%b mode=%0d period=%0d, required no event",
                 cyc, step_stb, err, valid, dir, mode, period);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc || step_stb !== e.stb || err !== e.er || valid !== e.vld ||
            dir !== e.d || mode !== e.m || period !== e.per) begin
          miscompares++;
          $display("FAIL output_event got cyc=%0d stb=%b err=%b valid=%b dir=%b mode=%0d period=%0d, required cyc=%0d stb=%b err=%b valid=%b dir=%b mode=%0d period=%0d",
                   cyc, step_stb, err, valid, dir, mode, period,
                   e.cyc, e.stb, e.er, e.vld, e.d, e.m, e.per);
        end
      end
      last_valid = valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d, required run to finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   r, h;
    bit   fwd;
    logic [3:0] p;
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prled_n = pat_at(2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    prled_n = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // forward at 30, reversal, backward at 100 then 10
    apply(4'b1110, 30); apply(4'b1101, 30); apply(4'b1011, 30);
    apply(4'b0111, 30); apply(4'b1110, 30);
    apply(4'b0111, 100); apply(4'b1011, 100); apply(4'b1101, 100);
    apply(4'b1110, 10); apply(4'b0111, 10); apply(4'b1011, 10); apply(4'b1101, 30);
    apply(4'b1011, 30); apply(4'b0111, 30); apply(4'b1011, 30);
    // illegal pattern, relock, illegal jump, relock
    apply(4'b1100, 20); apply(4'b1101, 30); apply(4'b1011, 30);
    apply(4'b0111, 30); apply(4'b1110, 30);
    apply(4'b1011, 30); apply(4'b0111, 30); apply(4'b1110, 30);
    // saturation boundary: 256 keeps lock, 257 drops it
    apply(4'b1101, 256); apply(4'b1011, 257);
    apply(4'b0111, 30); apply(4'b1110, 30); apply(4'b1101, 300);
    apply(4'b1011, 40); apply(4'b0111, 50); apply(4'b1110, 50);

    // reset mid-lock, asserted away from the clock edge
    @(posedge clk);
    #1 rst = 1'b0;
    prled_n = 4'b1111;
    stage = 0; mprev = 4'b1111; mdir = 1'b0; mmode = 2'd0; mper = 8'd0; cur = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    fwd = 1'b1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        p = cur;
        while (legal(p) || p == cur) p = 4'($urandom_range(0, 15));
      end else if (r < 9) begin
        p = pat_at(cpos + 2'd2);
      end else begin
        if ($urandom_range(0, 9) == 0) fwd = !fwd;
        p = pat_at(fwd ? cpos + 2'd1 : cpos - 2'd1);
      end
      h = ($urandom_range(0, 29) == 0) ? $urandom_range(250, 270) : $urandom_range(4, 90);
      apply(p, h);
    end
    apply(cur, 300);
    repeat (10) @(posedge clk);
    done = 1'b1;
  end

endmodule
